// File: rtl/cla_adder_pipe_if.sv
// cla_adder_pipe_if: valid/ready operand and result channels of the pipelined CLA adder
interface cla_adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: pipelined adder/subtractor resolving one 4-bit lookahead group per stage
module cla_adder_pipe #(
    parameter int WIDTH = 16
) (
    input logic             clk,
    input logic             rst,
    cla_adder_pipe_if.slave io
);
    localparam int NGRP = WIDTH / 4;

    logic adv;

    assign adv         = !io.out_valid || io.out_ready;
    assign io.in_ready = adv;

    for (genvar k = 0; k < NGRP; k++) begin : g
        localparam int LW = 4 * (k + 1);
        localparam int UW = WIDTH - LW;
        logic [3:0]    ga, gb, gg, gp, c;
        logic          ci, iv, c4, v, co;
        logic [LW-1:0] ns, s;
        if (k == 0) begin : f
            assign ga = io.a[3:0];
            assign gb = io.b[3:0] ^ {4{io.sub}};
            assign ci = io.sub | io.cin;
            assign iv = io.in_valid;
            assign ns = gp ^ c;
        end else begin : f
            assign ga = g[k-1].u.ua[3:0];
            assign gb = g[k-1].u.ub[3:0];
            assign ci = g[k-1].co;
            assign iv = g[k-1].v;
            assign ns = {gp ^ c, g[k-1].s};
        end
        assign gg   = ga & gb;
        assign gp   = ga ^ gb;
        assign c[0] = ci;
        assign c[1] = gg[0] | gp[0] & ci;
        assign c[2] = gg[1] | gp[1] & gg[0] | gp[1] & gp[0] & ci;
        assign c[3] = gg[2] | gp[2] & gg[1] | gp[2] & gp[1] & gg[0] | gp[2] & gp[1] & gp[0] & ci;
        assign c4   = gg[3] | gp[3] & gg[2] | gp[3] & gp[2] & gg[1]
                    | gp[3] & gp[2] & gp[1] & gg[0] | (&gp) & ci;
        always_ff @(posedge clk) begin
            if (rst) begin
                v  <= 1'b0;
                co <= 1'b0;
                s  <= '0;
            end else if (adv) begin
                v  <= iv;
                co <= c4;
                s  <= ns;
            end
        end
        // Operand bits not yet consumed travel alongside the partial sum
        if (UW > 0) begin : u
            logic [UW-1:0] ua, ub, na, nb;
            if (k == 0) begin : s0
                assign na = io.a[WIDTH-1:4];
                assign nb = io.b[WIDTH-1:4] ^ {UW{io.sub}};
            end else begin : sk
                assign na = g[k-1].u.ua[UW+3:4];
                assign nb = g[k-1].u.ub[UW+3:4];
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    ua <= '0;
                    ub <= '0;
                end else if (adv) begin
                    ua <= na;
                    ub <= nb;
                end
            end
        end
        if (k == NGRP - 1) begin : t
            logic ov;
            always_ff @(posedge clk) begin
                if (rst) ov <= 1'b0;
                else if (adv) ov <= c4 ^ c[3];
            end
            assign io.out_valid = v;
            assign io.sum       = s;
            assign io.cout      = co;
            assign io.ovf       = ov;
        end
    end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: random and directed stimulus against an arithmetic scoreboard model
module tb_cla_adder_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nmis = 0;
    int   npop = 0;
    logic [17:0] q[$];

    cla_adder_pipe_if #(.WIDTH(16)) bus ();

    cla_adder_pipe #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .io(bus));

    always #5 clk = ~clk;

    function automatic logic [17:0] model(logic [15:0] a, logic [15:0] b, logic cin, logic sub);
        int sa = $signed(a);
        int sb = $signed(b);
        int r;
        logic [16:0] u;
        if (sub) begin
            u = {1'b0, a} + 17'h10000 - {1'b0, b};
            r = sa - sb;
        end else begin
            u = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            r = sa + sb + int'(cin);
        end
        return {r > 32767 || r < -32768, u};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) q.delete();
        else begin
            if (bus.out_valid) begin
                if (q.size() == 0) chk("unexpected_out", 32'(bus.out_valid), 0);
                else begin
                    chk("result", 32'({bus.ovf, bus.cout, bus.sum}), 32'(q[0]));
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        npop++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
        end
    end

    task automatic send_one(input string nm, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub, input logic [17:0] exp);
        int n;
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        chk({nm, "_lat"}, n, 4);
        chk({nm, "_res"}, 32'({bus.ovf, bus.cout, bus.sum}), 32'(exp));
        repeat (2) step();
    endtask

    initial begin
        int i, cyc, seen, p0;
        logic acc;
        bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.cin = 0; bus.sub = 0; bus.out_ready = 0;
        chk("model_ffff_p1", 32'(model(16'hFFFF, 16'h0001, 0, 0)), 32'h10000);
        chk("model_7fff_p1", 32'(model(16'h7FFF, 16'h0001, 0, 0)), 32'h28000);
        chk("model_8000_m1", 32'(model(16'h8000, 16'h0001, 1, 1)), 32'h37FFF);
        chk("model_3_m5",    32'(model(16'h0003, 16'h0005, 0, 1)), 32'h0FFFE);
        repeat (2) step();
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_sum", 32'(bus.sum), 0);
        chk("rst_cout", 32'(bus.cout), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        rst = 1'b0;
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 1);

        send_one("add_wrap", 16'hFFFF, 16'h0001, 0, 0, 18'h10000);
        send_one("add_ovf",  16'h7FFF, 16'h0001, 0, 0, 18'h28000);
        send_one("sub_ovf",  16'h8000, 16'h0001, 1, 1, 18'h37FFF);
        send_one("sub_neg",  16'h0003, 16'h0005, 0, 1, 18'h0FFFE);

        // Back-to-back stream with a three-cycle consumer stall
        i = 0; cyc = 0; p0 = npop;
        while ((i < 8 || q.size() > 0) && cyc < 100) begin
            bus.in_valid = (i < 8);
            bus.a = 16'($urandom); bus.b = 16'($urandom);
            bus.cin = 1'($urandom); bus.sub = 1'($urandom);
            bus.out_ready = !(cyc >= 5 && cyc <= 7);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (!bus.out_ready) chk("stall_in_ready", 32'(bus.in_ready), 0);
            step();
            if (acc) i++;
            cyc++;
        end
        bus.in_valid = 0;
        chk("stream_sent", i, 8);
        chk("stream_cnt", npop - p0, 8);

        for (int c = 0; c < 400; c++) begin
            bus.in_valid = 1'($urandom);
            bus.a = 16'($urandom); bus.b = 16'($urandom);
            bus.cin = 1'($urandom); bus.sub = 1'($urandom);
            bus.out_ready = ($urandom_range(3) != 0);
            step();
        end
        bus.in_valid = 0; bus.out_ready = 1;
        cyc = 0;
        while (q.size() > 0 && cyc < 50) begin
            step();
            cyc++;
        end
        chk("random_drained", q.size(), 0);

        repeat (3) begin
            bus.in_valid = 1; bus.a = 16'($urandom); bus.b = 16'($urandom);
            step();
        end
        bus.in_valid = 0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            step();
            if (bus.out_valid) seen++;
        end
        chk("flush_no_out", seen, 0);
        send_one("post_rst", 16'h1234, 16'h4321, 0, 0, 18'h05555);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
